window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Builds 3x3 pixel neighbourhoods from a raster-order 8-bit pixel stream for the
//  edge-preserving noise filter. Feeds c1..c9 of add_pipeline_8bit, and any other
//  3x3 kernel, using two internal line buffers. One window is emitted per accepted
//  pixel once two full rows and two columns of the current row have been seen.
// PARAMETERS
//  DATA_W     8    pixel width in bits
//  IMG_WIDTH  640  pixels per line (>=3)
//  IMG_HEIGHT 480  lines per frame (>=3)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  sof         in   1       start of frame; qualified by pix_valid, marks pixel (0,0)
//  pix_valid   in   1       pixel strobe; pix_in accepted when high
//  pix_in      in   DATA_W  pixel, raster order
//  c1..c9      out  DATA_W  each; window: c1..c3=row y-2, c4..c6=row y-1, c7..c9=row y
//                           cols x-2,x-1,x left to right (c9 = newest pixel)
//  win_valid   out  1       c1..c9 hold a complete window
//  frame_done  out  1       one-cycle pulse after last pixel of a frame is accepted
// BEHAVIOUR
//  - Reset (rst_n=0): c1..c9=0, win_valid=0, frame_done=0, col=0, row=0. Line
//    buffer RAM contents are not reset and are don't-care.
//  - Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1. Both advance only on
//    pix_valid. At col=IMG_WIDTH-1: col->0, row++. At the last pixel of the frame
//    (col=W-1, row=H-1): row->0 and frame_done=1 next cycle.
//  - sof with pix_valid: pixel is taken as (0,0) whatever the counter state.
//    After it, col=1 and row=0. A mid-frame sof aborts the current frame with no
//    frame_done. Stale line data stays masked until row>=2.
//  - Line buffers: lb1 holds row y-1 and lb2 holds row y-2, each indexed by col.
//    On each accepted pixel: read lb1[col] and lb2[col], write lb2[col]<=lb1[col]
//    and lb1[col]<=pix_in. Read-before-write at the same address.
//  - Window shift (on accepted pixel): each row's 3 taps shift left. The new
//    rightmost taps are c3<=lb2[col], c6<=lb1[col], c9<=pix_in.
//  - Latency: 1 cycle. The window for pixel (x,y) appears on the clock after it is
//    accepted, with win_valid=1 iff x>=2 && y>=2 for that pixel.
//  - pix_valid=0: counters, buffers and c1..c9 hold; win_valid=0 on the next cycle.
//  - Row boundary: taps from the previous row's tail are shifted through.
//    win_valid masks them (x<2), so no zero padding is applied.
//  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - Reset asserted mid-frame: outputs clear at once, counters return to 0, and
//    the next accepted pixel is treated as (0,0).
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = {row,col} nibbles, e.g. (2,1)=0x21)
//  1 Reset: hold rst_n=0 with random inputs -> all c=0, win_valid=0, frame_done=0.
//  2 Continuous frame, sof on 0x00 -> 4 windows. First (after 0x22): c1..c9 =
//    00,01,02,10,11,12,20,21,22. Last (after 0x33): 11,12,13,21,22,23,31,32,33.
//  3 Same frame with pix_valid=0 every other cycle -> identical 4 windows,
//    win_valid low in the gap cycles, c values held.
//  4 Frame end -> frame_done=1 for exactly one cycle, one clock after 0x33.
//    A second frame run back-to-back -> same 4 windows.
//  5 sof asserted at pixel index 6 of a frame -> no frame_done. Next valid
//    window appears only after 10 further pixels and equals the case-2 values.
//  6 rst_n pulsed low mid-row 2 -> outputs 0 at once. Restart from sof ->
//    case-2 results exactly.

Source files
------------

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster-order pixel stream.
// Two line buffers supply rows y-1 and y-2; one window per accepted pixel with x>=2, y>=2.
module window_3x3_gen #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sof,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_in,
  output logic [DATA_W-1:0] o_c1,
  output logic [DATA_W-1:0] o_c2,
  output logic [DATA_W-1:0] o_c3,
  output logic [DATA_W-1:0] o_c4,
  output logic [DATA_W-1:0] o_c5,
  output logic [DATA_W-1:0] o_c6,
  output logic [DATA_W-1:0] o_c7,
  output logic [DATA_W-1:0] o_c8,
  output logic [DATA_W-1:0] o_c9,
  output logic              o_win_valid,
  output logic              o_frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic              w_last_col;
  logic              w_last_row;

  logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] w_lb1_rd;
  logic [DATA_W-1:0] w_lb2_rd;

  logic [DATA_W-1:0] r_c1, r_c2, r_c3, r_c4, r_c5, r_c6, r_c7, r_c8, r_c9;
  logic              r_win_valid;
  logic              r_frame_done;

  // A start-of-frame pixel is always position (0,0), regardless of where the counters were.
  always_comb begin
    w_col      = i_sof ? '0 : r_col;
    w_row      = i_sof ? '0 : r_row;
    w_last_col = (w_col == COL_LAST);
    w_last_row = (w_row == ROW_LAST);
    w_col_nxt  = w_col + 1'b1;
    w_row_nxt  = w_row;
    if (w_last_col) begin
      w_col_nxt = '0;
      w_row_nxt = w_last_row ? '0 : w_row + 1'b1;
    end
  end

  assign w_lb1_rd = r_lb1[w_col];
  assign w_lb2_rd = r_lb2[w_col];

  // Line buffer RAMs are deliberately left unreset; stale rows are masked by win_valid.
  always_ff @(posedge clk) begin
    if (i_pix_valid) begin
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= i_pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_c1         <= '0;
      r_c2         <= '0;
      r_c3         <= '0;
      r_c4         <= '0;
      r_c5         <= '0;
      r_c6         <= '0;
      r_c7         <= '0;
      r_c8         <= '0;
      r_c9         <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_pix_valid) begin
        r_col        <= w_col_nxt;
        r_row        <= w_row_nxt;
        r_c1         <= r_c2;
        r_c2         <= r_c3;
        r_c3         <= w_lb2_rd;
        r_c4         <= r_c5;
        r_c5         <= r_c6;
        r_c6         <= w_lb1_rd;
        r_c7         <= r_c8;
        r_c8         <= r_c9;
        r_c9         <= i_pix_in;
        r_win_valid  <= (w_col >= COL_TWO) && (w_row >= ROW_TWO);
        r_frame_done <= w_last_col && w_last_row;
      end
    end
  end

  assign o_c1         = r_c1;
  assign o_c2         = r_c2;
  assign o_c3         = r_c3;
  assign o_c4         = r_c4;
  assign o_c5         = r_c5;
  assign o_c6         = r_c6;
  assign o_c7         = r_c7;
  assign o_c8         = r_c8;
  assign o_c9         = r_c9;
  assign o_win_valid  = r_win_valid;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed, table-driven bench for window_3x3_gen on a 4x4 image where pixel (r,c) = {r,c} nibbles.
module tb_window_3x3_gen;

  logic       clk;
  logic       rst_n;
  logic       i_sof;
  logic       i_pix_valid;
  logic [7:0] i_pix_in;
  logic [7:0] o_c1, o_c2, o_c3, o_c4, o_c5, o_c6, o_c7, o_c8, o_c9;
  logic       o_win_valid;
  logic       o_frame_done;
  logic [71:0] win;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  pix;
    logic        expWv;
    logic        expFd;
    logic [71:0] expWin;
  } vec_t;

  vec_t frameVec[16];

  window_3x3_gen #(
    .DATA_W(8),
    .IMG_WIDTH(4),
    .IMG_HEIGHT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_sof(i_sof),
    .i_pix_valid(i_pix_valid),
    .i_pix_in(i_pix_in),
    .o_c1(o_c1),
    .o_c2(o_c2),
    .o_c3(o_c3),
    .o_c4(o_c4),
    .o_c5(o_c5),
    .o_c6(o_c6),
    .o_c7(o_c7),
    .o_c8(o_c8),
    .o_c9(o_c9),
    .o_win_valid(o_win_valid),
    .o_frame_done(o_frame_done)
  );

  assign win = {o_c1, o_c2, o_c3, o_c4, o_c5, o_c6, o_c7, o_c8, o_c9};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge that consumes them.
  task automatic applyStimulus(input logic sof, input logic valid, input logic [7:0] pix);
    i_sof       = sof;
    i_pix_valid = valid;
    i_pix_in    = pix;
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    i_sof       = 1'b0;
    i_pix_valid = 1'b0;
    i_pix_in    = 8'h00;
  endtask

  task automatic runFrame(input logic firstSof, input logic gaps, input string tag);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(firstSof && (i == 0), 1'b1, frameVec[i].pix);
      checkOutput($sformatf("%s pix%0d win_valid", tag, i), {71'd0, o_win_valid}, {71'd0, frameVec[i].expWv});
      checkOutput($sformatf("%s pix%0d frame_done", tag, i), {71'd0, o_frame_done}, {71'd0, frameVec[i].expFd});
      if (frameVec[i].expWv)
        checkOutput($sformatf("%s pix%0d window", tag, i), win, frameVec[i].expWin);
      if (gaps) begin
        applyStimulus(1'b0, 1'b0, 8'($urandom));
        checkOutput($sformatf("%s gap%0d win_valid", tag, i), {71'd0, o_win_valid}, 72'd0);
        checkOutput($sformatf("%s gap%0d frame_done", tag, i), {71'd0, o_frame_done}, 72'd0);
        if (frameVec[i].expWv)
          checkOutput($sformatf("%s gap%0d held window", tag, i), win, frameVec[i].expWin);
      end
    end
    goIdle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      frameVec[i].pix    = 8'(((i / 4) * 16) + (i % 4));
      frameVec[i].expWv  = 1'b0;
      frameVec[i].expFd  = 1'b0;
      frameVec[i].expWin = 72'd0;
    end
    frameVec[10].expWv  = 1'b1;
    frameVec[10].expWin = 72'h00_01_02_10_11_12_20_21_22;
    frameVec[11].expWv  = 1'b1;
    frameVec[11].expWin = 72'h01_02_03_11_12_13_21_22_23;
    frameVec[14].expWv  = 1'b1;
    frameVec[14].expWin = 72'h10_11_12_20_21_22_30_31_32;
    frameVec[15].expWv  = 1'b1;
    frameVec[15].expFd  = 1'b1;
    frameVec[15].expWin = 72'h11_12_13_21_22_23_31_32_33;

    // Reset held with random inputs.
    rst_n = 1'b0;
    goIdle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 8'($urandom));
      checkOutput("reset window", win, 72'd0);
      checkOutput("reset win_valid", {71'd0, o_win_valid}, 72'd0);
      checkOutput("reset frame_done", {71'd0, o_frame_done}, 72'd0);
    end
    goIdle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Continuous frame, gapped frame, then a back-to-back frame relying on counter wrap.
    runFrame(1'b1, 1'b0, "cont");
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("fd one cycle", {71'd0, o_frame_done}, 72'd0);
    runFrame(1'b1, 1'b1, "gaps");
    runFrame(1'b0, 1'b0, "b2b");
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("b2b fd one cycle", {71'd0, o_frame_done}, 72'd0);

    // Abort after six pixels with a fresh sof.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i == 0, 1'b1, frameVec[i].pix);
      checkOutput($sformatf("abort pix%0d win_valid", i), {71'd0, o_win_valid}, 72'd0);
      checkOutput($sformatf("abort pix%0d frame_done", i), {71'd0, o_frame_done}, 72'd0);
    end
    runFrame(1'b1, 1'b0, "resof");

    // Asynchronous reset in the middle of row 2.
    for (int i = 0; i < 10; i++)
      applyStimulus(i == 0, 1'b1, frameVec[i].pix);
    checkOutput("pre-reset c9", {64'd0, o_c9}, 72'h21);
    goIdle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset window", win, 72'd0);
    checkOutput("async reset win_valid", {71'd0, o_win_valid}, 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    runFrame(1'b1, 1'b0, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
